inst_fetch_unit: RTL and testbench

- Producer side of the instruction interface consumed by the control unit and decode stage.
- Holds the PC and issues word fetches to instruction memory over a request/response handshake.
- Buffers returned words in a small in-order queue and presents them with their PC as a valid/ready stream.
- Applies PC redirects from branch/JAL/JALR resolution, discarding wrong-path fetches that are still in flight.

---
 rtl/inst_fetch_unit_pkg.sv | 19 +
 rtl/inst_fetch_fifo.sv | 55 +++++
 rtl/inst_fetch_unit.sv | 94 +++++++++
 tb/tb_inst_fetch_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch-path definitions: instruction/PC widths, reset defaults and the
// queue entry layout used between the fetch unit and its instruction FIFO.
package inst_fetch_unit_pkg;

   localparam int          INST_W       = 32;
   localparam logic [31:0] PC_INC       = 32'd4;
   localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   typedef struct packed {
      logic [31:0]       pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return pc & ~32'h3;
   endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// In-order DEPTH-entry queue of {pc, inst}; flush wins over push/pop.
module inst_fetch_fifo
   import inst_fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  fetch_entry_t push_data_i,
   output fetch_entry_t head_o,
   output logic [CW-1:0] count_o,
   output logic         empty_o,
   output logic         full_o
);

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push, do_pop;

   assign do_push = push_i && !flush_i;
   assign do_pop  = pop_i && !flush_i && !empty_o;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // Pointers wrap naturally since DEPTH is a power of two.
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch front end: PC, credit-limited imem requests, wrong-path discard after
// redirects, and a valid/ready instruction stream to decode.
module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          DEPTH    = 2,
   parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, last_pc_q;
   logic [CW-1:0] outst_q, outst_d, disc_q, disc_d, fifo_count;
   logic [CW:0]   credit_used;
   logic          accept, keep_resp, pop, fifo_empty, fifo_full;
   fetch_entry_t  head;

   // Queued plus in-flight words never exceed DEPTH, so arrivals always fit.
   assign credit_used = {1'b0, fifo_count} + {1'b0, outst_q};
   assign imem_req    = !rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
   assign imem_addr   = fetch_pc_q;
   assign accept      = imem_req && imem_ready;
   assign keep_resp   = imem_rvalid && (disc_q == '0) && !redirect_valid;

   assign inst_valid = !fifo_empty && !redirect_valid;
   assign pop        = inst_valid && inst_ready;
   assign inst       = fifo_empty ? NOP_INST : head.inst;
   assign inst_pc    = fifo_empty ? last_pc_q : head.pc;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      disc_d     = disc_q;
      outst_d    = outst_q + CW'(accept) - CW'(imem_rvalid);
      if (redirect_valid) begin
         // Everything still in flight after this cycle belongs to the old path.
         fetch_pc_d = align_pc(redirect_pc);
         resp_pc_d  = align_pc(redirect_pc);
         disc_d     = outst_q - CW'(imem_rvalid);
      end else begin
         if (accept)    fetch_pc_d = fetch_pc_q + PC_INC;
         if (keep_resp) resp_pc_d = resp_pc_q + PC_INC;
         else if (imem_rvalid) disc_d = disc_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         last_pc_q  <= RESET_PC;
         outst_q    <= '0;
         disc_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         outst_q    <= outst_d;
         disc_q     <= disc_d;
         if (!fifo_empty) last_pc_q <= head.pc;
      end
   end

   inst_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (redirect_valid),
      .push_i      (keep_resp),
      .pop_i       (pop),
      .push_data_i ('{pc: resp_pc_q, inst: imem_rdata}),
      .head_o      (head),
      .count_o     (fifo_count),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full)
   );

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(keep_resp && fifo_full && !pop));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: in-order memory model with variable latency and a
// program-order PC model for requests and delivered instructions.
module tb_inst_fetch_unit;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req, imem_ready, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid, inst_ready;
   logic [31:0] inst, inst_pc;

   always #5 clk = ~clk;

   inst_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP_INST(NOP_INST)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   req_t        mq[$];
   int          checks = 0, errors = 0, cyc = 0;
   int          pops = 0, acc_cnt = 0;
   logic [31:0] exp_pc, exp_addr, last_pop_pc, last_acc_addr;
   logic [31:0] hold_inst, hold_pc;
   bit          hold_v = 0, wrap_seen = 0, samp_req, samp_valid;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at edge+1, sample at edge+4, advance the models after the edge.
   task automatic cycle(input bit redir, input logic [31:0] tgt, input bit irdy,
                        input bit rdy, input int lat);
      bit          acc, rv;
      logic [31:0] a;
      redirect_valid = redir;
      redirect_pc    = tgt;
      inst_ready     = irdy;
      imem_ready     = rdy;
      rv             = (mq.size() > 0) && (mq[0].due <= cyc);
      imem_rvalid    = rv;
      imem_rdata     = rv ? mq[0].addr : $urandom;
      #3;
      samp_req   = imem_req;
      samp_valid = inst_valid;
      chk("inflight_le_depth", 32'(mq.size() <= DEPTH), 32'd1);
      if (redir) begin
         chk("redir_req_low", 32'(imem_req), 32'd0);
         chk("redir_valid_low", 32'(inst_valid), 32'd0);
      end
      a   = imem_addr;
      acc = imem_req && rdy;
      if (acc) begin
         chk("req_addr", imem_addr, exp_addr);
         if (imem_addr == 32'h0 && last_acc_addr == 32'hFFFF_FFFC) wrap_seen = 1;
         last_acc_addr = imem_addr;
         exp_addr      = exp_addr + 32'd4;
         acc_cnt++;
      end
      if (hold_v && inst_valid) begin
         chk("stall_hold_inst", inst, hold_inst);
         chk("stall_hold_pc", inst_pc, hold_pc);
      end
      if (inst_valid && irdy) begin
         chk("deliver_pc", inst_pc, exp_pc);
         chk("deliver_inst", inst, exp_pc);
         last_pop_pc = inst_pc;
         exp_pc      = exp_pc + 32'd4;
         pops++;
      end
      hold_v    = inst_valid && !irdy && !redir;
      hold_inst = inst;
      hold_pc   = inst_pc;
      @(posedge clk);
      #1;
      if (rv) void'(mq.pop_front());
      if (acc) mq.push_back('{addr: a, due: cyc + lat});
      cyc++;
      if (redir) begin
         exp_pc   = tgt & ~32'h3;
         exp_addr = tgt & ~32'h3;
      end
   endtask

   initial begin
      bit found;
      int p0, a0;
      rst = 1'b1; imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
      redirect_valid = 0; redirect_pc = 0; inst_ready = 0;
      exp_pc = RESET_PC; exp_addr = RESET_PC; last_pop_pc = 0; last_acc_addr = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_req", 32'(imem_req), 32'd0);
      chk("reset_valid", 32'(inst_valid), 32'd0);
      chk("reset_inst", inst, NOP_INST);
      chk("reset_pc", inst_pc, RESET_PC);
      rst = 1'b0;

      // Steady stream, 1-cycle memory, decode always ready.
      for (int i = 0; i < 20; i++) cycle(0, 0, 1, 1, 1);
      chk("steady_throughput", 32'(pops >= 8), 32'd1);

      // Decode stall: credits run out and the head is held.
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 1);
      chk("stall_req_off", 32'(samp_req), 32'd0);
      chk("stall_valid_on", 32'(samp_valid), 32'd1);
      p0 = pops;
      for (int i = 0; i < 10; i++) cycle(0, 0, 1, 1, 1);
      chk("stall_resume", 32'(pops > p0), 32'd1);

      // Redirect with two requests in flight.
      found = 0;
      for (int i = 0; i < 12 && !found; i++)
         if (mq.size() == 2) found = 1; else cycle(0, 0, 1, 1, 3);
      chk("redir_two_outstanding", 32'(found), 32'd1);
      p0 = pops; a0 = acc_cnt;
      cycle(1, 32'h103, 1, 1, 3);
      for (int i = 0; i < 30 && acc_cnt == a0; i++) cycle(0, 0, 1, 1, 3);
      chk("redir_first_addr", last_acc_addr, 32'h100);
      for (int i = 0; i < 30 && pops == p0; i++) cycle(0, 0, 1, 1, 3);
      chk("redir_first_pc", last_pop_pc, 32'h100);

      // Redirect in the same cycle as a response, decode ready.
      found = 0;
      for (int i = 0; i < 20 && !found; i++)
         if (mq.size() > 0 && mq[0].due <= cyc) found = 1; else cycle(0, 0, 1, 1, 2);
      chk("coincide_found", 32'(found), 32'd1);
      p0 = pops;
      cycle(1, 32'h200, 1, 1, 2);
      chk("coincide_no_pop", pops, p0);
      for (int i = 0; i < 30 && pops == p0; i++) cycle(0, 0, 1, 1, 2);
      chk("coincide_first_pc", last_pop_pc, 32'h200);

      // Random ready, latency, decode backpressure and occasional redirects.
      p0 = pops;
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 99) < 3, $urandom, $urandom_range(0, 3) != 0,
               1'($urandom_range(0, 1)), $urandom_range(1, 4));
      chk("random_progress", 32'(pops > p0), 32'd1);

      // PC wrap at the top of the address space.
      cycle(1, 32'hFFFF_FFF8, 1, 1, 1);
      for (int i = 0; i < 20 && !wrap_seen; i++) cycle(0, 0, 1, 1, 1);
      chk("pc_wrap", 32'(wrap_seen), 32'd1);

      // Reset mid-burst.
      for (int i = 0; i < 6; i++) cycle(0, 0, 1, 1, 2);
      rst = 1'b1; imem_rvalid = 0; redirect_valid = 0;
      #1;
      chk("midrst_req", 32'(imem_req), 32'd0);
      chk("midrst_valid", 32'(inst_valid), 32'd0);
      chk("midrst_inst", inst, NOP_INST);
      chk("midrst_pc", inst_pc, RESET_PC);
      @(posedge clk);
      #1;
      rst = 1'b0;
      mq.delete();
      exp_pc = RESET_PC; exp_addr = RESET_PC; hold_v = 0;
      p0 = pops;
      for (int i = 0; i < 20 && pops == p0; i++) cycle(0, 0, 1, 1, 1);
      chk("midrst_restart_pc", last_pop_pc, RESET_PC);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
